mem_copy_engine: RTL and testbench
==================================

# mem_copy_engine

Bus initiator that copies a block of 32-bit words from one memory region to another, one read then one write per word, over the standard `Bus` interface. It drives the initiator side (`Bus.m`) and is paired with any `Bus.s` responder such as on-chip RAM. A one-cycle `start` pulse launches a copy. The engine reports `busy` while transferring and pulses `done` when finished.

## Interface
- `COUNT_WIDTH`, default 16: width of the word-count input; the maximum copy is 2^COUNT_WIDTH−1 words.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launches a copy; sampled only in IDLE.
- `src_address`  in  32  byte address of the first source word; bits [1:0] ignored and treated as 0.
- `dst_address`  in  32  byte address of the first destination word; bits [1:0] ignored and treated as 0.
- `word_count`  in  COUNT_WIDTH  number of words to copy.
- `busy`  out  1  high in READ and WRITE.
- `done`  out  1  one-cycle completion pulse.
- `bus`  Bus.m  initiator port: `valid`, `address`[31:0], `wstrobe`[3:0], `wdata`[31:0] out; `ready`, `rdata`[31:0] in.

## Operation
- Internal state: `src_ptr`, `dst_ptr` (32 bits each), `remaining` (COUNT_WIDTH bits), `data_reg` (32 bits), and FSM state.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: `bus.valid`=0, `busy`=0, `done`=0. When `start`=1:
  - latch `src_ptr`={src_address[31:2],2'b00}, `dst_ptr`={dst_address[31:2],2'b00}, `remaining`=`word_count`;
  - if `word_count`=0, go to DONE; otherwise go to READ.
- READ: `valid`=1, `address`=`src_ptr`, `wstrobe`=0, `wdata` don't-care.
  - While `ready`=0, hold all request signals stable.
  - When `valid`&&`ready`, capture `rdata` into `data_reg`, advance `src_ptr` by 4, go to WRITE.
- WRITE: `valid`=1, `address`=`dst_ptr`, `wstrobe`=4'b1111, `wdata`=`data_reg`.
  - Hold all request signals until `ready`=1.
  - On completion, advance `dst_ptr` by 4 and decrement `remaining`.
  - If the pre-decrement `remaining` was 1, go to DONE; otherwise go to READ.
- DONE: `done`=1, `busy`=0, `valid`=0; go to IDLE unconditionally.
- `start` is ignored in READ, WRITE and DONE; it is neither queued nor an error.
- Address arithmetic is modulo 2^32, so a pointer at 0xFFFF_FFFC advances to 0x0000_0000.
- Overlapping regions copy in ascending word order (forward copy). No overlap detection is performed.
- Request outputs are pure functions of registered state; there is no combinational path from `ready` to `valid`, `address`, `wstrobe` or `wdata`.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `bus.valid`=0, `bus.wstrobe`=0, `bus.address`=0, `bus.wdata`=0; pointers, `remaining` and `data_reg` are cleared.
- Reset during READ or WRITE: the FSM is in IDLE from the next cycle and the in-flight transfer is abandoned. A write whose `ready` coincided with the reset cycle may already have reached memory.
- Latency from `start` to `bus.valid`: `start` high in cycle k → READ asserted in cycle k+1.
- The responder may assert `ready` in the same cycle `valid` rises (zero wait) or any number of cycles later. A transfer completes exactly in the cycle where `valid`&&`ready`.
- Back-to-back transfers: the next request is presented in the cycle immediately after completion, with `valid` held continuously high through READ→WRITE→READ.
- With zero-wait reads and writes, N words take 2N busy cycles. `done` rises in cycle k+1+2N, and IDLE accepts a new `start` in cycle k+2+2N.
- With 1-wait reads and zero-wait writes, each word takes 3 cycles.
- `word_count`=0: no bus activity; `done` pulses in cycle k+1.

## Test plan
- Zero-wait RAM model, src=0x100 holding 0x11111111, 0x22222222, 0x33333333, dst=0x200, count=3, `start` in cycle 5 → 6 busy cycles (6–11), addresses 0x100,0x200,0x104,0x204,0x108,0x208, dst contents match, `done` in cycle 12 only.
- Responder with 1-wait reads (ready toggles) and zero-wait writes, count=4 → 12 busy cycles; `address`/`wstrobe` stable during every wait cycle; data matches.
- count=0 with `start` → no `valid` ever; `done` the next cycle; `busy` never high.
- src=0xFFFF_FFF8, count=3 → read addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; misaligned src=0x103 treated as 0x100.
- `start` pulsed again in the cycle after launch and during DONE → ignored; exactly one copy and one `done`.
- `reset` asserted in the second WRITE of a count=5 copy → `valid`=0, `busy`=0 next cycle; a new `start` (count=1) then completes normally.

Source files
------------

// File: rtl/mem_copy_engine_if.sv
// Initiator/responder bus used by the copy engine: one request per cycle,
// a transfer completes in the cycle where valid && ready.
interface mem_copy_engine_if;
  logic        valid;
  logic [31:0] address;
  logic [3:0]  wstrobe;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport m (
    output valid, address, wstrobe, wdata,
    input  ready, rdata
  );

  modport s (
    input  valid, address, wstrobe, wdata,
    output ready, rdata
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine: one bus read then one bus write per word,
// ascending addresses, all request outputs driven from registers.
module mem_copy_engine #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            src_address,
  input  logic [31:0]            dst_address,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic                   busy,
  output logic                   done,
  mem_copy_engine_if.m           bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam logic [31:0] WORD_MASK = ~32'h3;

  state_t                 state;
  logic [31:0]            src_ptr;
  logic [31:0]            dst_ptr;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [31:0]            data_reg;
  logic                   valid_q;
  logic [31:0]            address_q;
  logic [3:0]             wstrobe_q;

  assign bus.valid   = valid_q;
  assign bus.address = address_q;
  assign bus.wstrobe = wstrobe_q;
  assign bus.wdata   = data_reg;

  // NOTE: every register here is updated with <= so all branches see the
  // pre-edge values; the next request is loaded alongside the state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      data_reg  <= '0;
      valid_q   <= 1'b0;
      address_q <= '0;
      wstrobe_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            src_ptr   <= src_address & WORD_MASK;
            dst_ptr   <= dst_address & WORD_MASK;
            remaining <= word_count;
            if (word_count == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state     <= ST_READ;
              busy      <= 1'b1;
              valid_q   <= 1'b1;
              address_q <= src_address & WORD_MASK;
              wstrobe_q <= 4'h0;
            end
          end
        end

        ST_READ: begin
          if (bus.ready) begin
            data_reg  <= bus.rdata;
            src_ptr   <= src_ptr + 32'd4;
            state     <= ST_WRITE;
            address_q <= dst_ptr;
            wstrobe_q <= 4'hf;
          end
        end

        ST_WRITE: begin
          if (bus.ready) begin
            dst_ptr   <= dst_ptr + 32'd4;
            remaining <= remaining - COUNT_WIDTH'(1);
            if (remaining == COUNT_WIDTH'(1)) begin
              state     <= ST_DONE;
              valid_q   <= 1'b0;
              wstrobe_q <= 4'h0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              // src_ptr was already advanced when the read completed
              state     <= ST_READ;
              address_q <= src_ptr;
              wstrobe_q <= 4'h0;
            end
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: a RAM responder with selectable wait
// behaviour, a copy reference model feeding an expected-transaction queue.
module tb_mem_copy_engine;
  localparam int COUNT_WIDTH = 16;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrobe;
    logic [31:0] data;
  } txn_t;

  logic                   clk;
  logic                   reset;
  logic                   start;
  logic [31:0]            src_address;
  logic [31:0]            dst_address;
  logic [COUNT_WIDTH-1:0] word_count;
  logic                   busy;
  logic                   done;

  mem_copy_engine_if bus ();

  mem_copy_engine #(.COUNT_WIDTH(COUNT_WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .src_address (src_address),
    .dst_address (dst_address),
    .word_count  (word_count),
    .busy        (busy),
    .done        (done),
    .bus         (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wait_mode = 0;  // 0: zero-wait, 1: one-wait reads, 2: random waits

  logic [31:0] ram     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  txn_t        sb_q    [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 32'h0;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    ram[a]     = d;
    ref_mem[a] = d;
  endtask

  // Reference model: a forward word copy over the shadow memory, emitting the
  // expected read/write sequence.
  task automatic model_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
    logic [31:0] s;
    logic [31:0] d;
    logic [31:0] w;
    s = src & ~32'h3;
    d = dst & ~32'h3;
    for (int i = 0; i < n; i++) begin
      w = ref_rd(s);
      ref_mem[d] = w;
      sb_q.push_back('{addr: s, wstrobe: 4'h0, data: 32'h0});
      sb_q.push_back('{addr: d, wstrobe: 4'hf, data: w});
      s = s + 32'd4;
      d = d + 32'd4;
    end
  endtask

  // RAM responder: drives ready/rdata just after the edge, commits at negedge.
  initial begin
    int hold;
    int need;
    int rand_wait;
    hold = 0;
    rand_wait = 0;
    bus.ready = 1'b0;
    bus.rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      case (wait_mode)
        1:       need = (bus.wstrobe == 4'h0) ? 1 : 0;
        2:       need = rand_wait;
        default: need = 0;
      endcase
      bus.ready = bus.valid && (hold >= need);
      bus.rdata = ram_rd(bus.address);
      @(negedge clk);
      if (bus.valid && bus.ready) begin
        if (bus.wstrobe == 4'hf) ram[bus.address] = bus.wdata;
        hold = 0;
        rand_wait = $urandom_range(0, 2);
      end else if (bus.valid) begin
        hold++;
      end else begin
        hold = 0;
      end
    end
  end

  // Monitor: request stability during waits, and scoreboard pops on completion.
  initial begin
    logic        prev_wait;
    logic [31:0] prev_addr;
    logic [3:0]  prev_wstrobe;
    logic [31:0] prev_wdata;
    txn_t        t;
    prev_wait = 1'b0;
    prev_addr = '0;
    prev_wstrobe = '0;
    prev_wdata = '0;
    forever begin
      @(negedge clk);
      if (prev_wait && bus.valid) begin
        check("hold_address", bus.address, prev_addr);
        check("hold_wstrobe", {28'h0, bus.wstrobe}, {28'h0, prev_wstrobe});
        if (bus.wstrobe == 4'hf) check("hold_wdata", bus.wdata, prev_wdata);
      end
      if (bus.valid && bus.ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_txn: got address %h with nothing expected", bus.address);
        end else begin
          t = sb_q.pop_front();
          check("txn_address", bus.address, t.addr);
          check("txn_wstrobe", {28'h0, bus.wstrobe}, {28'h0, t.wstrobe});
          if (t.wstrobe == 4'hf) check("txn_wdata", bus.wdata, t.data);
        end
      end
      prev_wait    = bus.valid && !bus.ready;
      prev_addr    = bus.address;
      prev_wstrobe = bus.wstrobe;
      prev_wdata   = bus.wdata;
    end
  end

  task automatic do_copy(input logic [31:0] src, input logic [31:0] dst, input int n,
                         input int mode, input bit restart);
    int k;
    int busy_cyc = 0;
    int valid_cyc = 0;
    int first_valid = -1;
    int dones = 0;
    int done_cyc = -1;
    int tail = 0;
    int late_valid = 0;
    int exp_cycles;
    bit finished = 1'b0;
    logic [31:0] a;
    wait_mode = mode;
    model_copy(src, dst, n);
    @(negedge clk);
    src_address = src;
    dst_address = dst;
    word_count  = COUNT_WIDTH'(n);
    start       = 1'b1;
    k           = cyc;
    for (int c = 0; c < 2000 && !finished; c++) begin
      @(negedge clk);
      if (dones > 0) begin
        tail++;
        if (bus.valid) late_valid++;
      end
      if (busy) busy_cyc++;
      if (bus.valid) begin
        valid_cyc++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      start = restart && (cyc == k + 1 || done);
      if (tail >= 6) finished = 1'b1;
    end
    start = 1'b0;
    if (!finished) begin
      n_checks++;
      n_fail++;
      $display("FAIL copy_timeout: got %0d done pulses, required completion within budget", dones);
    end
    exp_cycles = (mode == 0) ? 2 * n : (mode == 1) ? 3 * n : -1;
    check("done_count", dones, 1);
    if (exp_cycles >= 0) begin
      check("busy_cycles", busy_cyc, exp_cycles);
      check("done_latency", done_cyc - k, exp_cycles + 1);
    end
    if (n == 0) check("valid_cycles", valid_cyc, 0);
    else        check("first_valid_latency", first_valid - k, 1);
    check("late_valid", late_valid, 0);
    check("sb_empty", sb_q.size(), 0);
    for (int i = 0; i < n; i++) begin
      a = (dst & ~32'h3) + 32'(4 * i);
      check("dst_data", ram_rd(a), ref_rd(a));
    end
  endtask

  initial begin
    int wr;
    bit hit;
    reset = 1'b1;
    start = 1'b0;
    src_address = '0;
    dst_address = '0;
    word_count  = '0;
    repeat (3) @(negedge clk);
    check("rst_valid",   {31'h0, bus.valid}, 32'h0);
    check("rst_busy",    {31'h0, busy}, 32'h0);
    check("rst_done",    {31'h0, done}, 32'h0);
    check("rst_wstrobe", {28'h0, bus.wstrobe}, 32'h0);
    check("rst_address", bus.address, 32'h0);
    check("rst_wdata",   bus.wdata, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic zero-wait copy with known contents
    poke(32'h100, 32'h1111_1111);
    poke(32'h104, 32'h2222_2222);
    poke(32'h108, 32'h3333_3333);
    do_copy(32'h100, 32'h200, 3, 0, 1'b0);
    check("basic_w0", ram_rd(32'h200), 32'h1111_1111);
    check("basic_w1", ram_rd(32'h204), 32'h2222_2222);
    check("basic_w2", ram_rd(32'h208), 32'h3333_3333);

    // One-wait reads, zero-wait writes
    for (int i = 0; i < 4; i++) poke(32'h400 + 32'(4 * i), $urandom);
    do_copy(32'h400, 32'h480, 4, 1, 1'b0);

    // Zero-length copy
    do_copy(32'h800, 32'h900, 0, 0, 1'b0);

    // Address wrap and misaligned inputs
    poke(32'hFFFF_FFF8, $urandom);
    poke(32'hFFFF_FFFC, $urandom);
    poke(32'h0000_0000, $urandom);
    do_copy(32'hFFFF_FFF8, 32'h700, 3, 0, 1'b0);
    do_copy(32'h103, 32'h306, 2, 2, 1'b0);

    // Repeated start after launch and during the done cycle
    do_copy(32'h400, 32'hA00, 3, 0, 1'b1);

    // Overlapping forward copy with random wait states
    for (int i = 0; i < 6; i++) poke(32'h1000 + 32'(4 * i), $urandom);
    do_copy(32'h1000, 32'h1008, 6, 2, 1'b0);

    // Reset during the second write of a five-word copy
    for (int i = 0; i < 5; i++) poke(32'hC00 + 32'(4 * i), $urandom);
    wait_mode = 0;
    model_copy(32'hC00, 32'hD00, 5);
    @(negedge clk);
    src_address = 32'hC00;
    dst_address = 32'hD00;
    word_count  = COUNT_WIDTH'(5);
    start       = 1'b1;
    wr  = 0;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.valid && bus.wstrobe == 4'hf) wr++;
      if (wr == 2) begin
        reset = 1'b1;
        hit = 1'b1;
      end
    end
    if (!hit) begin
      n_checks++;
      n_fail++;
      $display("FAIL reset_write_timeout: got %0d writes, required 2", wr);
    end
    @(negedge clk);
    check("abort_valid", {31'h0, bus.valid}, 32'h0);
    check("abort_busy",  {31'h0, busy}, 32'h0);
    check("abort_done",  {31'h0, done}, 32'h0);
    reset = 1'b0;
    sb_q.delete();
    ref_mem = ram;
    do_copy(32'hC00, 32'hE00, 1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
